// File: rtl/iterative_divider_if.sv
// Start/busy/done handshake between pipeline control and the iterative divider.
// The pipeline side uses the master modport, the divider the slave modport.
interface iterative_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/iterative_divider.sv
// Restoring 32-bit divider, one quotient bit per cycle through Comparator_32bit.
// Signed DIV/REM support is built only when DIVIDER_SIGNED_EN is defined.
module Comparator_32bit (
    input  logic [31:0] m,
    input  logic [31:0] n,
    output logic        result
);
    assign result = (m >= n);
endmodule

module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    iterative_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] r, q, dvs;
    logic [4:0]       cnt;
    logic             dz_flag;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             done_q, dz_q;

    logic             accept, is_zero, is_ovf;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             carry, cmp_ge, ge;
    logic [WIDTH-1:0] t, diff, q_fix, r_fix;

    // A start arriving in the done cycle is dropped; restart is one cycle later.
    assign accept  = (state == IDLE) && bus.start && !done_q;
    assign is_zero = (bus.divisor == '0);

    assign {carry, t} = {r, q[WIDTH-1]};
    assign diff       = t - dvs;
    assign ge         = carry | cmp_ge;

    Comparator_32bit u_cmp (
        .m      (t),
        .n      (dvs),
        .result (cmp_ge)
    );

`ifdef DIVIDER_SIGNED_EN
    logic sign_q, sign_r, q_neg, r_neg, special;

    always_comb begin
        dvd_mag = bus.dividend;
        dvs_mag = bus.divisor;
        sign_q  = 1'b0;
        sign_r  = 1'b0;
        is_ovf  = 1'b0;
        if (bus.is_signed) begin
            if (bus.dividend[WIDTH-1]) dvd_mag = -bus.dividend;
            if (bus.divisor[WIDTH-1])  dvs_mag = -bus.divisor;
            sign_q = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r = bus.dividend[WIDTH-1];
            is_ovf = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.divisor);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            special <= 1'b0;
        end else if (accept) begin
            q_neg   <= sign_q;
            r_neg   <= sign_r;
            special <= is_zero | is_ovf;
        end
    end

    // Special-case results were loaded already signed, so they bypass the fix.
    always_comb begin
        q_fix = q;
        r_fix = r;
        if (!special) begin
            if (q_neg) q_fix = -q;
            if (r_neg) r_fix = -r;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = bus.is_signed;

    always_comb begin
        dvd_mag = bus.dividend;
        dvs_mag = bus.divisor;
        is_ovf  = 1'b0;
        q_fix   = q;
        r_fix   = r;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.busy   = (state != IDLE);
        case (state)
            IDLE: if (accept) state_next = (is_zero || is_ovf) ? FIX : RUN;
            RUN:  if (cnt == 5'd0) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            cnt         <= 5'd0;
            dz_flag     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvs     <= dvs_mag;
                        cnt     <= 5'd31;
                        dz_flag <= is_zero;
                        if (is_zero) begin
                            q <= '1;
                            r <= bus.dividend;
                        end else if (is_ovf) begin
                            q <= {1'b1, {(WIDTH-1){1'b0}}};
                            r <= '0;
                        end else begin
                            q <= dvd_mag;
                            r <= '0;
                        end
                    end
                end
                RUN: begin
                    r   <= ge ? diff : t;
                    q   <= {q[WIDTH-2:0], ge};
                    cnt <= cnt - 5'd1;
                end
                FIX: begin
                    quotient_q  <= q_fix;
                    remainder_q <= r_fix;
                    dz_q        <= dz_flag;
                    done_q      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dz_q;
endmodule
